// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the data-memory access unit.
package mem_access_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(size_e size, logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_be(size_e size, logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate right-justified store data across every lane it could land in.
  function automatic logic [DATA_W-1:0] lane_wdata(size_e size, logic [DATA_W-1:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      SZ_WORD: return wdata;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a read word and extends it.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  size_e             size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select followed by zero/sign extension; words pass through.
  always_comb begin
    byte_lane = rdata[7:0];
    case (addr)
      2'b00: byte_lane = rdata[7:0];
      2'b01: byte_lane = rdata[15:8];
      2'b10: byte_lane = rdata[23:16];
      2'b11: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: rdata_ext = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SZ_HALF: rdata_ext = {{16{sign_ext & half_lane[15]}}, half_lane};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller between the core's request port and a synchronous SRAM.
// Handshakes: a transfer happens on a rising clock edge where valid && ready;
// valid and the payload are held until that edge, and ready never depends on valid.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_e            dbg_state
);

  // Counter starts at latency-1 so that WAIT lasts exactly MEM_LATENCY cycles.
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              r_write;
  size_e             r_size;
  logic              r_signed;
  logic [1:0]        r_addr_lo;
  logic [DATA_W-1:0] rdata_ext;
  size_e             req_sz;
  logic              req_bad;

  assign dbg_state = state;
  assign req_sz    = size_e'(req_size);
  assign req_bad   = (req_sz == SZ_ILL) || is_misaligned(req_sz, req_addr[1:0]);

  load_extend u_load_extend (
    .rdata     (mem_rdata),
    .addr      (r_addr_lo),
    .size      (r_size),
    .sign_ext  (r_signed),
    .rdata_ext (rdata_ext)
  );

  // Request/issue/wait/respond sequencer; all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      r_write    <= 1'b0;
      r_size     <= SZ_BYTE;
      r_signed   <= 1'b0;
      r_addr_lo  <= 2'b00;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            r_write   <= req_write;
            r_size    <= req_sz;
            r_signed  <= req_signed;
            r_addr_lo <= req_addr[1:0];
            if (req_bad) begin
              // Bad requests never reach the SRAM.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= ISSUE;
              mem_en    <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= req_addr[ADDR_W-1:2];
              mem_be    <= lane_be(req_sz, req_addr[1:0]);
              mem_wdata <= req_write ? lane_wdata(req_sz, req_wdata) : '0;
            end
          end
        end
        ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_be    <= '0;
          mem_wdata <= '0;
          if (r_write) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state <= WAIT;
            cnt   <= LAT_M1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= rdata_ext;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: instance 0 with MEM_LATENCY=1, instance 1 with
// MEM_LATENCY=3, both fed by a small latency-exact SRAM read model.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals (index = instance) ----------------
  logic [1:0]        req_valid, req_ready, resp_valid, resp_ready, resp_err, mem_en, mem_we;
  logic              req_write, req_signed;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic [1:0][31:0]  resp_rdata, mem_wdata, mem_rdata;
  logic [1:0][29:0]  mem_addr;
  logic [1:0][3:0]   mem_be;
  state_e            dbg_state0, dbg_state1;

  mem_access_unit #(.MEM_LATENCY(1), .ADDR_W(32)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_be(mem_be[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .dbg_state(dbg_state0)
  );

  mem_access_unit #(.MEM_LATENCY(3), .ADDR_W(32)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_be(mem_be[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .dbg_state(dbg_state1)
  );

  // ---------------- SRAM read model: data only in the exact latency cycle ----------------
  logic [31:0]      sram [16];
  logic [1:0][2:0]  pv;
  logic [1:0][2:0][29:0] pa;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      pa <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        pv[k] <= {pv[k][1:0], mem_en[k] & ~mem_we[k]};
        pa[k] <= {pa[k][1:0], mem_addr[k]};
      end
    end
  end

  assign mem_rdata[0] = pv[0][0] ? sram[pa[0][0][3:0]] : JUNK;
  assign mem_rdata[1] = pv[1][2] ? sram[pa[1][2][3:0]] : JUNK;

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  function automatic logic [31:0] ext_ref(input logic [31:0] word, input logic [1:0] sz,
                                          input logic sg, input logic [1:0] lo);
    logic [31:0] sh;
    if (sz == 2'b00) begin
      sh = word >> (8 * lo);
      return sg ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
    end
    if (sz == 2'b01) begin
      sh = word >> (16 * lo[1]);
      return sg ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
    end
    return word;
  endfunction

  task automatic check_idle(input int inst, input string tag);
    check({tag, "/ctrl"}, 64'({req_ready[inst], resp_valid[inst], resp_err[inst],
                               mem_en[inst], mem_we[inst], mem_be[inst]}), 64'h100);
    check({tag, "/data"}, {resp_rdata[inst], mem_wdata[inst]}, 64'h0);
    check({tag, "/addr"}, 64'(mem_addr[inst]), 64'h0);
  endtask

  // One request: drive at cycle T, expect response at T+lat, hold off resp_ready
  // for 'stall' cycles, then complete the handshake.
  task automatic run_req(input int inst, input string tag, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                         input logic err, input logic [31:0] exp_rd, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input int lat, input int stall);
    int en_cnt, issue_at, waited;
    logic cap_we;
    logic [3:0] cap_be;
    logic [29:0] cap_addr;
    logic [31:0] cap_wd;
    logic [32:0] got, exp;
    en_cnt = 0; issue_at = 0; waited = 0;
    cap_we = 1'b0; cap_be = '0; cap_addr = '0; cap_wd = '0;
    while (!req_ready[inst] && waited < 20) begin
      cycle();
      waited++;
    end
    check({tag, "/req_ready"}, 64'(req_ready[inst]), 64'h1);
    req_valid[inst] = 1'b1;
    req_write = w; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    exp_q.push_back({err, exp_rd});
    for (int i = 1; i <= lat; i++) begin
      cycle();
      if (i == 1) req_valid[inst] = 1'b0;
      if (mem_en[inst]) begin
        en_cnt++;
        issue_at = i;
        cap_we = mem_we[inst]; cap_be = mem_be[inst];
        cap_addr = mem_addr[inst]; cap_wd = mem_wdata[inst];
      end
      if (i < lat) check({tag, "/early_resp"}, 64'(resp_valid[inst]), 64'h0);
    end
    check({tag, "/resp_valid"}, 64'({resp_valid[inst], req_ready[inst]}), 64'h2);
    check({tag, "/mem_en_cnt"}, 64'(en_cnt), err ? 64'h0 : 64'h1);
    if (!err) begin
      check({tag, "/issue_cycle"}, 64'(issue_at), 64'h1);
      check({tag, "/mem_we"}, 64'(cap_we), 64'(w));
      check({tag, "/mem_addr"}, 64'(cap_addr), 64'(addr >> 2));
      check({tag, "/mem_be"}, 64'(cap_be), 64'(exp_be));
      if (w) check({tag, "/mem_wdata"}, 64'(cap_wd), 64'(exp_wd));
    end
    got = {resp_err[inst], resp_rdata[inst]};
    if (exp_q.size() == 0) begin
      check({tag, "/queue_empty"}, 64'h1, 64'h0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    check({tag, "/resp"}, 64'(got), 64'(exp));
    for (int s = 0; s < stall; s++) begin
      cycle();
      check({tag, "/stall_hold"}, 64'({resp_valid[inst], req_ready[inst], resp_err[inst],
                                       resp_rdata[inst]}), 64'({2'b10, exp}));
    end
    resp_ready[inst] = 1'b1;
    cycle();
    resp_ready[inst] = 1'b0;
    check({tag, "/after_hs"}, 64'({resp_valid[inst], req_ready[inst]}), 64'h1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int seen;
    logic [1:0] rsz, rlo;
    logic rsg;
    reset = 1'b0;
    req_valid = '0; resp_ready = '0;
    req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) sram[i] = 32'h0;
    sram[0] = 32'h1280_3456;
    sram[1] = 32'h8001_7FFE;
    cycle(); cycle();
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    check("reset_state", 64'({dbg_state0, dbg_state1}), 64'({IDLE, IDLE}));
    reset = 1'b1;
    cycle();

    // Stores (instance 0)
    run_req(0, "st_word", 1, 2'b10, 0, 32'h100, 32'hDEAD_BEEF, 0, 0, 4'b1111, 32'hDEAD_BEEF, 2, 0);
    run_req(0, "st_byte", 1, 2'b00, 0, 32'h103, 32'h0000_00A5, 0, 0, 4'b1000, 32'hA5A5_A5A5, 2, 0);
    run_req(0, "st_half", 1, 2'b01, 0, 32'h102, 32'h0000_1234, 0, 0, 4'b1100, 32'h1234_1234, 2, 0);

    // Loads (instance 0, MEM_LATENCY=1)
    run_req(0, "ld_b_s",  0, 2'b00, 1, 32'h102, 0, 0, 32'hFFFF_FF80, 4'b0100, 0, 3, 0);
    run_req(0, "ld_b_u",  0, 2'b00, 0, 32'h102, 0, 0, 32'h0000_0080, 4'b0100, 0, 3, 0);
    run_req(0, "ld_h_s",  0, 2'b01, 1, 32'h102, 0, 0, 32'h0000_1280, 4'b1100, 0, 3, 0);
    run_req(0, "ld_b1_u", 0, 2'b00, 0, 32'h101, 0, 0, 32'h0000_0034, 4'b0010, 0, 3, 0);
    run_req(0, "ld_w",    0, 2'b10, 1, 32'h100, 0, 0, 32'h1280_3456, 4'b1111, 0, 3, 0);

    // Misaligned / illegal: error after one cycle, no memory cycle
    run_req(0, "err_half", 0, 2'b01, 0, 32'h101, 0, 1, 0, 0, 0, 1, 0);
    run_req(0, "err_word", 1, 2'b10, 0, 32'h102, 32'h1111_2222, 1, 0, 0, 0, 1, 0);
    run_req(0, "err_ill",  0, 2'b11, 0, 32'h100, 0, 1, 0, 0, 0, 1, 1);

    // Random lane/sign loads against the reference extractor
    sram[2] = $urandom;
    for (int n = 0; n < 8; n++) begin
      rsz = 2'($urandom_range(0, 1));
      rlo = 2'($urandom_range(0, 3));
      if (rsz == 2'b01) rlo[0] = 1'b0;
      rsg = 1'($urandom_range(0, 1));
      run_req(0, "ld_rand", 0, rsz, rsg, {28'h0000_010, 2'b10, rlo}, 0, 0,
              ext_ref(sram[2], rsz, rsg, rlo),
              (rsz == 2'b00) ? (4'b0001 << rlo) : (rlo[1] ? 4'b1100 : 4'b0011), 0, 3, 0);
    end

    // MEM_LATENCY=3 (instance 1): stalled response must hold steady
    run_req(1, "l3_h_u", 0, 2'b01, 0, 32'h106, 0, 0, 32'h0000_8001, 4'b1100, 0, 5, 4);
    run_req(1, "l3_h_s", 0, 2'b01, 1, 32'h106, 0, 0, 32'hFFFF_8001, 4'b1100, 0, 5, 0);
    run_req(1, "l3_w",   0, 2'b10, 0, 32'h104, 0, 0, 32'h8001_7FFE, 4'b1111, 0, 5, 2);
    run_req(1, "l3_st",  1, 2'b00, 0, 32'h105, 32'h0000_003C, 0, 0, 4'b0010, 32'h3C3C_3C3C, 2, 0);

    // Reset while instance 1 is in WAIT: access discarded, no response
    req_valid[1] = 1'b1;
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h104;
    cycle();
    req_valid[1] = 1'b0;
    check("rst_wait/issue", 64'(mem_en[1]), 64'h1);
    cycle();
    check("rst_wait/in_wait", 64'(dbg_state1), 64'(WAIT));
    reset = 1'b0;
    #1;
    check_idle(1, "rst_wait/async");
    cycle();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (resp_valid[1]) seen++;
    end
    check("rst_wait/no_resp", 64'(seen), 64'h0);
    run_req(1, "post_rst", 0, 2'b00, 1, 32'h107, 0, 0, 32'hFFFF_FF80, 4'b1000, 0, 5, 0);

    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access controller between the processor core's load/store port and a synchronous data SRAM.
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the SRAM with byte-lane enables and replicated store data, then waits a fixed memory latency.
- Returns sign- or zero-extended load data, or flags misaligned and illegal accesses without touching memory.

Parameters:
- MEM_LATENCY, 1: cycles from the cycle mem_en is high to the cycle mem_rdata is valid; legal range 1..15.
- ADDR_W, 32: byte-address width of req_addr.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  sign-extend a load (ignored for stores and word loads)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal access
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W-2  word address, req_addr[ADDR_W-1:2]
- mem_be  out  4  byte-lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  SRAM read data

Behaviour:
- Reset (reset low, asynchronous): state IDLE; every output 0 except req_ready = 1. Any in-flight access is discarded; no response is issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid && req_ready, register the request.
    - Misaligned or illegal request → RESP with resp_err = 1.
    - Otherwise → ISSUE.
  - ISSUE (exactly one cycle): mem_en = 1; mem_we = req_write; mem_addr, mem_be and mem_wdata are driven from registered values.
    - Store → RESP.
    - Load → WAIT, with the counter loaded to MEM_LATENCY-1.
  - WAIT: counter decrements each cycle. When it reaches 0, capture mem_rdata (extended) at that clock edge → RESP.
    - With MEM_LATENCY = 1, WAIT lasts one cycle.
  - RESP: resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready. On resp_valid && resp_ready → IDLE.
- req_ready is 0 in every state except IDLE. A new request cannot be accepted in the same cycle as a response handshake.
- Latency, with the request handshake in cycle T:
  - error: resp_valid from T+1
  - store: resp_valid from T+2
  - load: resp_valid from T+2+MEM_LATENCY
- mem_en, mem_we, mem_be and mem_wdata are 0 outside ISSUE. mem_addr holds its last value.
- Misalignment and illegal requests:
  - halfword with addr[0] = 1 is misaligned
  - word with addr[1:0] ≠ 00 is misaligned
  - size 11 is illegal
  - No memory cycle is issued for any of these.
- Store steering:
  - byte: mem_be = 4'b0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}
  - half: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}
  - word: mem_be = 1111; mem_wdata = wdata
- Load extraction:
  - The lane is selected by addr[1:0] (byte) or addr[1] (half).
  - Zero-extend, or sign-extend when req_signed = 1.
  - A word load returns mem_rdata unchanged.

Decomposition:
- Package mem_access_pkg:
  - size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL)
  - state_e enum (IDLE, ISSUE, WAIT, RESP)
  - function is_misaligned(size, addr[1:0])
- Sub-module load_extend: purely combinational; inputs rdata, addr[1:0], size, signed; output rdata_ext.

Test Plan:
- Word store, addr 0x100, wdata 0xDEADBEEF, MEM_LATENCY = 1 → ISSUE at T+1 with mem_be = 1111, mem_addr = 0x40, mem_we = 1; resp_valid at T+2, resp_err = 0, resp_rdata = 0.
- Byte store, addr 0x103, wdata 0x000000A5 → mem_be = 1000, mem_wdata = 0xA5A5A5A5; halfword store, addr 0x102, wdata 0x1234 → mem_be = 1100, mem_wdata = 0x12341234.
- Byte load, addr 0x102, mem_rdata = 0x12803456: signed → 0xFFFFFF80, unsigned → 0x00000080. Halfword load, addr 0x102, signed → 0x00001280.
- Halfword load at 0x101, word store at 0x102, and size 11 → resp_err = 1 at T+1; mem_en never asserted.
- MEM_LATENCY = 3 load, with resp_ready held low for 4 cycles → resp_valid at T+5; resp_rdata stable while stalled; req_ready stays 0 until the cycle after the response handshake.
- MEM_LATENCY = 3: reset asserted during WAIT → all outputs 0 and req_ready = 1 immediately; no resp_valid after release; the next request completes normally.
